ahb_lite_cordic_mc: RTL

AHB-Lite slave fronting N_CH independent CORDIC channels, each with an input push port and a show-ahead result FIFO. Successor to the single-channel CORDIC bridge: parametrised channel count and data width, a per-channel register window, true wait-state back-pressure on writes and blocking reads, timeout-to-ERROR, and sticky status flags. Sits on the SoC AHB-Lite bus between the matrix and the CORDIC cores/FIFOs.

---
 rtl/cordic_ahb_pkg.sv | 31 +++
 rtl/cordic_ahb_chan_regs.sv | 48 ++++
 rtl/ahb_lite_cordic_mc.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cordic_ahb_pkg.sv
// =============================================================================
// cordic_ahb_pkg: shared offsets, register bit indices and FSM state encoding.
// Rev 1.0
// =============================================================================
`default_nettype none

package cordic_ahb_pkg;

  localparam logic [1:0] c_off_data_in  = 2'd0;
  localparam logic [1:0] c_off_data_out = 2'd1;
  localparam logic [1:0] c_off_status   = 2'd2;
  localparam logic [1:0] c_off_ctrl     = 2'd3;

  localparam int c_st_empty_bit = 0;
  localparam int c_st_ready_bit = 1;
  localparam int c_st_uf_bit    = 2;
  localparam int c_st_to_bit    = 3;
  localparam int c_ctrl_block_bit = 0;

  localparam int c_def_timeout = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cordic_ahb_chan_regs.sv
// =============================================================================
// cordic_ahb_chan_regs: per-channel CTRL.BLOCK bit and sticky status flags.
// Rev 1.0
// =============================================================================
`default_nettype none

module cordic_ahb_chan_regs
  import cordic_ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_ctrl_we,
  input  logic i_block_wdata,
  input  logic i_set_uf,
  input  logic i_clr_uf,
  input  logic i_set_to,
  input  logic i_clr_to,
  output logic o_block,
  output logic o_underflow,
  output logic o_timeout
);

  logic r_block;
  logic r_uf;
  logic r_to;

  // A hardware set in the same cycle as a software clear keeps the flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_block <= 1'b0;
      r_uf    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      if (i_ctrl_we) r_block <= i_block_wdata;
      if (i_set_uf)      r_uf <= 1'b1;
      else if (i_clr_uf) r_uf <= 1'b0;
      if (i_set_to)      r_to <= 1'b1;
      else if (i_clr_to) r_to <= 1'b0;
    end
  end

  assign o_block     = r_block;
  assign o_underflow = r_uf;
  assign o_timeout   = r_to;

endmodule

`default_nettype wire

// File: rtl/ahb_lite_cordic_mc.sv
// =============================================================================
// ahb_lite_cordic_mc: AHB-Lite slave fronting N_CH CORDIC push ports and FIFOs.
// Rev 1.0
// =============================================================================
`default_nettype none

module ahb_lite_cordic_mc
  import cordic_ahb_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = c_def_timeout
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               i_hsel,
  input  logic               i_hready,
  input  logic               i_hwrite,
  input  logic [31:0]        i_haddr,
  input  logic [1:0]         i_htrans,
  input  logic [2:0]         i_hsize,
  input  logic [2:0]         i_hburst,
  input  logic [3:0]         i_hprot,
  input  logic               i_hmastlock,
  input  logic [31:0]        i_hwdata,
  output logic               o_hreadyout,
  output logic               o_hresp,
  output logic [31:0]        o_hrdata,
  output logic [N_CH*DW-1:0] o_cordic_in_data,
  output logic [N_CH-1:0]    o_cordic_in_valid,
  input  logic [N_CH-1:0]    i_cordic_in_ready,
  output logic [N_CH-1:0]    o_fifo_rd_en,
  input  logic [N_CH*DW-1:0] i_fifo_rd_data,
  input  logic [N_CH-1:0]    i_fifo_empty
);

  state_t      r_state;
  logic [3:0]  r_ch;
  logic [1:0]  r_off;
  logic        r_write;
  logic        r_inrng;
  logic [15:0] r_wait_cnt;

  logic            w_accept, w_addr_inrng, w_xfer, w_take;
  logic [N_CH-1:0] w_sel, w_block, w_uf, w_to;
  logic            w_empty, w_ready, w_sel_block, w_sel_uf, w_sel_to;
  logic [DW-1:0]   w_head;
  logic            w_is_push, w_is_rd_out, w_wait, w_timeout, w_pop, w_underflow;
  logic            w_stat_wr, w_ctrl_wr;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_accept     = i_hsel & i_hready & i_htrans[1];
  assign w_addr_inrng = ({1'b0, i_haddr[7:4]} < 5'(N_CH));
  assign w_xfer       = (r_state == ST_XFER);

  // Live per-channel signals selected by the latched channel; all zero out of range.
  always_comb begin
    w_sel       = '0;
    w_empty     = 1'b0;
    w_ready     = 1'b0;
    w_head      = '0;
    w_sel_block = 1'b0;
    w_sel_uf    = 1'b0;
    w_sel_to    = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      w_sel[c] = r_inrng && (r_ch == 4'(c));
      if (w_sel[c]) begin
        w_empty     = i_fifo_empty[c];
        w_ready     = i_cordic_in_ready[c];
        w_head      = i_fifo_rd_data[c*DW +: DW];
        w_sel_block = w_block[c];
        w_sel_uf    = w_uf[c];
        w_sel_to    = w_to[c];
      end
    end
  end

  assign w_is_push   = w_xfer & r_inrng & r_write & (r_off == c_off_data_in);
  assign w_is_rd_out = w_xfer & r_inrng & ~r_write & (r_off == c_off_data_out);
  assign w_stat_wr   = w_xfer & r_inrng & r_write & (r_off == c_off_status);
  assign w_ctrl_wr   = w_xfer & r_inrng & r_write & (r_off == c_off_ctrl);

  assign w_wait      = (w_is_push & ~w_ready) | (w_is_rd_out & w_empty & w_sel_block);
  // The TIMEOUT-th wait cycle is the last one; the next cycle is ERR1.
  assign w_timeout   = w_wait & (({1'b0, r_wait_cnt} + 17'd1) == 17'(TIMEOUT));
  assign w_pop       = w_is_rd_out & ~w_empty;
  assign w_underflow = w_is_rd_out & w_empty & ~w_sel_block;

  assign w_take = w_accept & ((r_state == ST_IDLE) | (r_state == ST_ERR2) | (w_xfer & ~w_wait));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_ch       <= '0;
      r_off      <= '0;
      r_write    <= 1'b0;
      r_inrng    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_XFER: begin
          if (w_timeout)   r_state    <= ST_ERR1;
          else if (w_wait) r_wait_cnt <= r_wait_cnt + 16'd1;
          else             r_state    <= w_accept ? ST_XFER : ST_IDLE;
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: r_state <= w_accept ? ST_XFER : ST_IDLE;
      endcase
      if (w_take) begin
        r_ch       <= i_haddr[7:4];
        r_off      <= i_haddr[3:2];
        r_write    <= i_hwrite;
        r_inrng    <= w_addr_inrng;
        r_wait_cnt <= '0;
      end
    end
  end

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      cordic_ahb_chan_regs u_regs (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .i_ctrl_we     (w_ctrl_wr & w_sel[c]),
        .i_block_wdata (i_hwdata[c_ctrl_block_bit]),
        .i_set_uf      (w_underflow & w_sel[c]),
        .i_clr_uf      (w_stat_wr & w_sel[c] & i_hwdata[c_st_uf_bit]),
        .i_set_to      (w_timeout & w_sel[c]),
        .i_clr_to      (w_stat_wr & w_sel[c] & i_hwdata[c_st_to_bit]),
        .o_block       (w_block[c]),
        .o_underflow   (w_uf[c]),
        .o_timeout     (w_to[c])
      );
    end
  endgenerate

  always_comb begin
    w_status                 = '0;
    w_status[c_st_empty_bit] = w_empty;
    w_status[c_st_ready_bit] = w_ready;
    w_status[c_st_uf_bit]    = w_sel_uf;
    w_status[c_st_to_bit]    = w_sel_to;
  end

  always_comb begin
    o_hrdata = '0;
    if (w_xfer && r_inrng && !r_write) begin
      case (r_off)
        c_off_data_out: o_hrdata = w_empty ? 32'd0 : 32'(w_head);
        c_off_status:   o_hrdata = w_status;
        c_off_ctrl:     o_hrdata = {31'd0, w_sel_block};
        default:        o_hrdata = '0;
      endcase
    end
  end

  always_comb begin
    o_cordic_in_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_is_push && w_sel[c]) o_cordic_in_data[c*DW +: DW] = i_hwdata[DW-1:0];
    end
  end

  assign o_cordic_in_valid = w_is_push ? w_sel : '0;
  assign o_fifo_rd_en      = w_pop ? w_sel : '0;

  always_comb begin
    case (r_state)
      ST_XFER: o_hreadyout = ~w_wait;
      ST_ERR1: o_hreadyout = 1'b0;
      default: o_hreadyout = 1'b1;
    endcase
  end

  assign o_hresp = (r_state == ST_ERR1) | (r_state == ST_ERR2);

  assign w_unused = ^{i_hsize, i_hburst, i_hprot, i_hmastlock, i_htrans[0],
                      i_haddr[31:8], i_haddr[1:0], i_hwdata};

endmodule

`default_nettype wire
